// File: rtl/uncache_bridge_pkg.sv
// Shared definitions for the uncached peripheral bridge: FSM state encodings
// and AXI response codes.
package uncache_bridge_pkg;

  typedef enum logic [2:0] {
    UB_IDLE  = 3'd0,
    UB_RD_A  = 3'd1,
    UB_RD_D  = 3'd2,
    UB_WR_AW = 3'd3,
    UB_WR_B  = 3'd4,
    UB_RESP  = 3'd5
  } ub_state_e;

  localparam logic [1:0] AXI_OKAY   = 2'b00;
  localparam logic [1:0] AXI_SLVERR = 2'b10;
  localparam logic [1:0] AXI_DECERR = 2'b11;

  function automatic logic ub_resp_is_err(input logic [1:0] resp);
    return resp != AXI_OKAY;
  endfunction

endpackage

// File: rtl/uncache_bridge.sv
// Runs one translated uncached load/store as a single-beat AXI4-Lite-style
// transaction, with a saturating watchdog that aborts accesses to dead slaves.
module uncache_bridge
  import uncache_bridge_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_paddr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [3:0]        req_wstrb,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              ar_valid,
  input  logic              ar_ready,
  output logic [ADDR_W-1:0] ar_addr,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [DATA_W-1:0] r_data,
  input  logic [1:0]        r_resp,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ADDR_W-1:0] aw_addr,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic [3:0]        w_strb,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [1:0]        b_resp
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  ub_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [3:0]        wstrb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_ready_q, resp_valid_q, err_q;
  logic              ar_valid_q, r_ready_q, aw_valid_q, w_valid_q, b_ready_q;
  logic              aw_done_q, w_done_q;

  logic [CNT_W-1:0]  cnt_d;
  logic              aw_done_d, w_done_d;
  logic              complete_d, abort_d;

  // A data/response handshake landing on the last allowed cycle still wins
  // over the watchdog; address-phase handshakes do not.
  always_comb begin
    cnt_d      = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
    aw_done_d  = aw_done_q | (aw_valid_q & aw_ready);
    w_done_d   = w_done_q | (w_valid_q & w_ready);
    complete_d = ((state_q == UB_RD_D) & r_valid) | ((state_q == UB_WR_B) & b_valid);
    abort_d    = (cnt_d == CNT_MAX) & ~complete_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= UB_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      cnt_q        <= '0;
    end else begin
      case (state_q)
        UB_IDLE: begin
          if (req_valid) begin
            addr_q      <= req_paddr;
            wdata_q     <= req_wdata;
            wstrb_q     <= req_wstrb;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            req_ready_q <= 1'b0;
            if (req_we) begin
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
              state_q    <= UB_WR_AW;
            end else begin
              ar_valid_q <= 1'b1;
              state_q    <= UB_RD_A;
            end
          end
        end
        UB_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= UB_IDLE;
          end
        end
        default: begin
          cnt_q <= cnt_d;
          if (abort_d) begin
            ar_valid_q   <= 1'b0;
            r_ready_q    <= 1'b0;
            aw_valid_q   <= 1'b0;
            w_valid_q    <= 1'b0;
            b_ready_q    <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b1;
            resp_valid_q <= 1'b1;
            state_q      <= UB_RESP;
          end else begin
            case (state_q)
              UB_RD_A: begin
                if (ar_ready) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state_q    <= UB_RD_D;
                end
              end
              UB_RD_D: begin
                if (r_valid) begin
                  r_ready_q    <= 1'b0;
                  rdata_q      <= r_data;
                  err_q        <= ub_resp_is_err(r_resp);
                  resp_valid_q <= 1'b1;
                  state_q      <= UB_RESP;
                end
              end
              UB_WR_AW: begin
                aw_done_q <= aw_done_d;
                w_done_q  <= w_done_d;
                if (aw_valid_q & aw_ready) aw_valid_q <= 1'b0;
                if (w_valid_q & w_ready) w_valid_q <= 1'b0;
                if (aw_done_d & w_done_d) begin
                  b_ready_q <= 1'b1;
                  state_q   <= UB_WR_B;
                end
              end
              UB_WR_B: begin
                if (b_valid) begin
                  b_ready_q    <= 1'b0;
                  rdata_q      <= '0;
                  err_q        <= ub_resp_is_err(b_resp);
                  resp_valid_q <= 1'b1;
                  state_q      <= UB_RESP;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign ar_valid   = ar_valid_q;
  assign ar_addr    = addr_q;
  assign r_ready    = r_ready_q;
  assign aw_valid   = aw_valid_q;
  assign aw_addr    = addr_q;
  assign w_valid    = w_valid_q;
  assign w_data     = wdata_q;
  assign w_strb     = wstrb_q;
  assign b_ready    = b_ready_q;

endmodule

// File: tb/tb_uncache_bridge.sv
// Self-checking bench for uncache_bridge: directed scenarios plus randomized
// traffic, all compared every cycle against a transaction-level model.
module tb_uncache_bridge;

  localparam int TO       = 1023;
  localparam int M_RANDOM = 0;
  localparam int M_ZERO   = 1;
  localparam int M_DEAD   = 2;
  localparam int M_MANUAL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
  logic [31:0] req_paddr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        ar_valid, r_ready, aw_valid, w_valid, b_ready;
  logic [31:0] ar_addr, aw_addr, w_data;
  logic [3:0]  w_strb;
  logic        ar_ready, r_valid, aw_ready, w_ready, b_valid;
  logic [31:0] r_data;
  logic [1:0]  r_resp, b_resp;

  int          mode = M_MANUAL;
  logic        man_ar_ready = 0, man_r_valid = 0, man_aw_ready = 0, man_w_ready = 0, man_b_valid = 0;
  logic [31:0] man_r_data = '0;
  logic [1:0]  man_r_resp = '0, man_b_resp = '0;
  logic        sl_ar_ready = 0, sl_r_valid = 0, sl_aw_ready = 0, sl_w_ready = 0, sl_b_valid = 0;
  logic [31:0] sl_r_data = '0;
  logic [1:0]  sl_r_resp = '0, sl_b_resp = '0;
  logic        fix_en = 0;
  logic [31:0] fix_rdata = '0;
  logic [1:0]  fix_resp = '0;

  int errors = 0;
  int checks = 0;

  assign ar_ready = (mode == M_MANUAL) ? man_ar_ready : sl_ar_ready;
  assign r_valid  = (mode == M_MANUAL) ? man_r_valid  : sl_r_valid;
  assign r_data   = (mode == M_MANUAL) ? man_r_data   : sl_r_data;
  assign r_resp   = (mode == M_MANUAL) ? man_r_resp   : sl_r_resp;
  assign aw_ready = (mode == M_MANUAL) ? man_aw_ready : sl_aw_ready;
  assign w_ready  = (mode == M_MANUAL) ? man_w_ready  : sl_w_ready;
  assign b_valid  = (mode == M_MANUAL) ? man_b_valid  : sl_b_valid;
  assign b_resp   = (mode == M_MANUAL) ? man_b_resp   : sl_b_resp;

  uncache_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_paddr(req_paddr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] pickResp();
    int v;
    v = int'($urandom % 8);
    if (v == 5) return 2'b10;
    if (v == 6) return 2'b11;
    if (v == 7) return 2'b01;
    return 2'b00;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level expectation: which channel the bridge owes, and what the
  // pending response must carry. Event flags are computed from the pre-edge
  // model state before any update is applied.
  logic        idle_m = 1, ar_pend_m = 0, r_wait_m = 0, aw_pend_m = 0, w_pend_m = 0;
  logic        b_wait_m = 0, resp_pend_m = 0, exp_err_m = 0;
  logic [31:0] addr_m = '0, wdata_m = '0, exp_rdata_m = '0;
  logic [3:0]  wstrb_m = '0;
  int          cyc_m = 0;

  initial begin : model
    logic acc, arh, awh, wh, rh, bh, rsh, busy;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        idle_m = 1; ar_pend_m = 0; r_wait_m = 0; aw_pend_m = 0; w_pend_m = 0;
        b_wait_m = 0; resp_pend_m = 0; exp_err_m = 0; exp_rdata_m = '0; cyc_m = 0;
      end else begin
        acc  = idle_m && req_valid;
        arh  = ar_pend_m && ar_ready;
        awh  = aw_pend_m && aw_ready;
        wh   = w_pend_m && w_ready;
        rh   = r_wait_m && r_valid;
        bh   = b_wait_m && b_valid;
        rsh  = resp_pend_m && resp_ready;
        busy = !idle_m && !resp_pend_m;
        if (rsh) begin
          resp_pend_m = 0;
          idle_m = 1;
        end
        if (acc) begin
          idle_m = 0; cyc_m = 0;
          addr_m = req_paddr; wdata_m = req_wdata; wstrb_m = req_wstrb;
          if (req_we) begin aw_pend_m = 1; w_pend_m = 1; end
          else ar_pend_m = 1;
        end
        if (busy) begin
          cyc_m++;
          if (rh) begin
            r_wait_m = 0; resp_pend_m = 1;
            exp_rdata_m = r_data; exp_err_m = (r_resp != 2'b00);
          end else if (bh) begin
            b_wait_m = 0; resp_pend_m = 1;
            exp_rdata_m = '0; exp_err_m = (b_resp != 2'b00);
          end else if (cyc_m >= TO) begin
            ar_pend_m = 0; r_wait_m = 0; aw_pend_m = 0; w_pend_m = 0; b_wait_m = 0;
            resp_pend_m = 1; exp_rdata_m = '0; exp_err_m = 1;
          end else begin
            if (arh) begin ar_pend_m = 0; r_wait_m = 1; end
            if (awh) aw_pend_m = 0;
            if (wh) w_pend_m = 0;
            if ((awh || wh) && !aw_pend_m && !w_pend_m) b_wait_m = 1;
          end
        end
      end
    end
  end

  // Every cycle out of reset, the DUT outputs must match the model's view.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst) begin
        checkOutput("req_ready", req_ready, idle_m);
        checkOutput("ar_valid", ar_valid, ar_pend_m);
        if (ar_pend_m) checkOutput("ar_addr", ar_addr, addr_m);
        checkOutput("r_ready", r_ready, r_wait_m);
        checkOutput("aw_valid", aw_valid, aw_pend_m);
        if (aw_pend_m) checkOutput("aw_addr", aw_addr, addr_m);
        checkOutput("w_valid", w_valid, w_pend_m);
        if (w_pend_m) begin
          checkOutput("w_data", w_data, wdata_m);
          checkOutput("w_strb", w_strb, wstrb_m);
        end
        checkOutput("b_ready", b_ready, b_wait_m);
        checkOutput("resp_valid", resp_valid, resp_pend_m);
        if (resp_pend_m) begin
          checkOutput("resp_rdata", resp_rdata, exp_rdata_m);
          checkOutput("resp_err", resp_err, exp_err_m);
        end
      end
    end
  end

  // Behavioural slave for the random/zero-wait modes; it honours AXI rules
  // (a raised valid stays up until its handshake).
  initial begin : slave
    logic arh, awh, wh, rh, bh, zero;
    int rd_owed, aw_cnt, w_cnt;
    rd_owed = 0; aw_cnt = 0; w_cnt = 0;
    forever begin
      @(posedge clk);
      arh = ar_valid && ar_ready;
      awh = aw_valid && aw_ready;
      wh  = w_valid && w_ready;
      rh  = r_valid && r_ready;
      bh  = b_valid && b_ready;
      #1;
      if (!rst || mode == M_MANUAL || mode == M_DEAD) begin
        rd_owed = 0; aw_cnt = 0; w_cnt = 0;
        sl_ar_ready = 0; sl_aw_ready = 0; sl_w_ready = 0; sl_r_valid = 0; sl_b_valid = 0;
      end else begin
        zero = (mode == M_ZERO);
        if (arh) rd_owed++;
        if (awh) aw_cnt++;
        if (wh) w_cnt++;
        if (rh) begin sl_r_valid = 0; rd_owed--; end
        if (bh) sl_b_valid = 0;
        if (!sl_r_valid && rd_owed > 0 && (zero || $urandom % 3 == 0)) begin
          sl_r_valid = 1;
          sl_r_data  = fix_en ? fix_rdata : $urandom;
          sl_r_resp  = fix_en ? fix_resp : pickResp();
        end
        if (!sl_b_valid && aw_cnt > 0 && w_cnt > 0 && (zero || $urandom % 3 == 0)) begin
          aw_cnt--; w_cnt--;
          sl_b_valid = 1;
          sl_b_resp  = fix_en ? fix_resp : pickResp();
        end
        sl_ar_ready = zero || ($urandom % 2 == 0);
        sl_aw_ready = zero || ($urandom % 2 == 0);
        sl_w_ready  = zero || ($urandom % 2 == 0);
      end
    end
  end

  // Presents one request and returns in the cycle after it was accepted.
  task automatic applyStimulus(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] wstrb);
    bit seen;
    seen = 0;
    tick();
    req_valid = 1; req_we = we; req_paddr = addr; req_wdata = wdata; req_wstrb = wstrb;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) begin seen = 1; break; end
    end
    if (!seen) checkOutput("accept_bound", 0, 1);
    tick();
    req_valid = 0;
  endtask

  task automatic waitResp(output logic [31:0] data, output logic err);
    bit seen;
    seen = 0; data = '0; err = 0;
    for (int i = 0; i < TO + 50; i++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1; data = resp_rdata; err = resp_err; break; end
    end
    if (!seen) checkOutput("resp_wait_bound", 0, 1);
  endtask

  initial begin : main
    logic [31:0] d;
    logic        e;
    int          cnt, cnt2;
    bit          drained;

    #1 rst = 0;
    @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 1);
    checkOutput("rst_ar_valid", ar_valid, 0);
    checkOutput("rst_aw_valid", aw_valid, 0);
    checkOutput("rst_w_valid", w_valid, 0);
    checkOutput("rst_r_ready", r_ready, 0);
    checkOutput("rst_b_ready", b_ready, 0);
    checkOutput("rst_resp_valid", resp_valid, 0);
    checkOutput("rst_rdata", resp_rdata, 0);
    checkOutput("rst_err", resp_err, 0);
    checkOutput("rst_ar_addr", ar_addr, 0);
    @(negedge clk);
    #2 rst = 1;

    // Zero-wait read with exact cycle positions.
    mode = M_ZERO; fix_en = 1; fix_rdata = 32'hdead_beef; fix_resp = 2'b00;
    applyStimulus(0, 32'h1faf_f020, 32'h0, 4'h0);
    @(negedge clk);
    checkOutput("rd0_c1_ar_valid", ar_valid, 1);
    checkOutput("rd0_c1_ar_addr", ar_addr, 32'h1faf_f020);
    @(negedge clk);
    checkOutput("rd0_c2_r_ready", r_ready, 1);
    checkOutput("rd0_c2_resp_valid", resp_valid, 0);
    @(negedge clk);
    checkOutput("rd0_c3_resp_valid", resp_valid, 1);
    checkOutput("rd0_c3_rdata", resp_rdata, 32'hdead_beef);
    checkOutput("rd0_c3_err", resp_err, 0);

    // Write: W accepted at once, AW three cycles later.
    mode = M_MANUAL; man_aw_ready = 0; man_w_ready = 1; man_b_valid = 0;
    applyStimulus(1, 32'h1fd0_0000, 32'h1234_5678, 4'b0011);
    @(negedge clk);
    checkOutput("wr_c1_w_data", w_data, 32'h1234_5678);
    checkOutput("wr_c1_w_strb", w_strb, 4'b0011);
    tick(); man_w_ready = 0;
    @(negedge clk);
    checkOutput("wr_c2_w_valid", w_valid, 0);
    checkOutput("wr_c2_aw_valid", aw_valid, 1);
    tick();
    @(negedge clk);
    checkOutput("wr_c3_aw_valid", aw_valid, 1);
    tick(); man_aw_ready = 1;
    tick(); man_aw_ready = 0; man_b_valid = 1; man_b_resp = 2'b00;
    @(negedge clk);
    checkOutput("wr_c5_b_ready", b_ready, 1);
    checkOutput("wr_c5_aw_valid", aw_valid, 0);
    tick(); man_b_valid = 0;
    @(negedge clk);
    checkOutput("wr_c6_resp_valid", resp_valid, 1);
    checkOutput("wr_c6_err", resp_err, 0);
    checkOutput("wr_c6_rdata", resp_rdata, 0);
    checkOutput("wr_c6_b_ready", b_ready, 0);

    // SLVERR read, then an OKAY read straight after.
    mode = M_ZERO; fix_rdata = 32'h0bad_f00d; fix_resp = 2'b10;
    applyStimulus(0, 32'h1faf_0004, 32'h0, 4'h0);
    waitResp(d, e);
    checkOutput("slverr_err", e, 1);
    checkOutput("slverr_rdata", d, 32'h0bad_f00d);
    fix_resp = 2'b00; fix_rdata = 32'h0000_0042;
    applyStimulus(0, 32'h1faf_0008, 32'h0, 4'h0);
    waitResp(d, e);
    checkOutput("okay_after_err", e, 0);
    checkOutput("okay_after_rdata", d, 32'h0000_0042);

    // Dead slave: AR held for exactly TO cycles, then an error response.
    mode = M_DEAD;
    applyStimulus(0, 32'h1faf_ff00, 32'h0, 4'h0);
    cnt = 0;
    for (int i = 0; i < TO + 20; i++) begin
      @(negedge clk);
      if (ar_valid) cnt++;
      else break;
    end
    checkOutput("dead_ar_cycles", cnt, TO);
    checkOutput("dead_resp_valid", resp_valid, 1);
    checkOutput("dead_err", resp_err, 1);
    checkOutput("dead_rdata", resp_rdata, 0);
    tick();
    mode = M_MANUAL; man_r_valid = 1; man_r_data = 32'h5555_aaaa; man_r_resp = 2'b00;
    cnt = 0; cnt2 = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) cnt++;
      if (r_ready) cnt2++;
    end
    checkOutput("late_r_resp_count", cnt, 0);
    checkOutput("late_r_ready_count", cnt2, 0);
    tick(); man_r_valid = 0;

    // Response backpressure with a new request waiting.
    mode = M_ZERO; fix_resp = 2'b00; fix_rdata = 32'hcafe_0001; resp_ready = 0;
    applyStimulus(0, 32'h1faf_1000, 32'h0, 4'h0);
    req_valid = 1; req_we = 0; req_paddr = 32'h1faf_2000;
    waitResp(d, e);
    for (int k = 0; k < 5; k++) begin
      checkOutput("bp_resp_valid", resp_valid, 1);
      checkOutput("bp_rdata", resp_rdata, 32'hcafe_0001);
      checkOutput("bp_req_ready", req_ready, 0);
      tick();
      if (k == 4) resp_ready = 1;
      @(negedge clk);
    end
    checkOutput("bp_last_resp_valid", resp_valid, 1);
    checkOutput("bp_last_req_ready", req_ready, 0);
    tick();
    @(negedge clk);
    checkOutput("bp_idle_req_ready", req_ready, 1);
    tick(); req_valid = 0;
    @(negedge clk);
    checkOutput("bp_next_ar_addr", ar_addr, 32'h1faf_2000);
    waitResp(d, e);
    checkOutput("bp_next_rdata", d, 32'hcafe_0001);

    // Asynchronous reset while waiting for B.
    mode = M_MANUAL; man_aw_ready = 1; man_w_ready = 1; man_b_valid = 0;
    applyStimulus(1, 32'h1fd0_0010, 32'hffff_0000, 4'b0000);
    tick();
    @(negedge clk);
    checkOutput("wrb_b_ready", b_ready, 1);
    #2 rst = 0;
    #1;
    checkOutput("arst_b_ready", b_ready, 0);
    checkOutput("arst_aw_valid", aw_valid, 0);
    checkOutput("arst_w_valid", w_valid, 0);
    checkOutput("arst_resp_valid", resp_valid, 0);
    checkOutput("arst_req_ready", req_ready, 1);
    @(negedge clk);
    #2 rst = 1;
    @(negedge clk);
    checkOutput("post_rst_req_ready", req_ready, 1);
    mode = M_ZERO; fix_rdata = 32'h1357_2468; fix_resp = 2'b00;
    applyStimulus(0, 32'h1faf_3000, 32'h0, 4'h0);
    waitResp(d, e);
    checkOutput("post_rst_rdata", d, 32'h1357_2468);
    checkOutput("post_rst_err", e, 0);

    // Randomized traffic against the model.
    mode = M_RANDOM; fix_en = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      req_valid  = ($urandom % 3 == 0);
      req_we     = $urandom % 2;
      req_paddr  = $urandom;
      req_wdata  = $urandom;
      req_wstrb  = ($urandom % 5 == 0) ? 4'h0 : 4'($urandom);
      resp_ready = ($urandom % 4 != 0);
    end
    tick();
    req_valid = 0; resp_ready = 1;
    drained = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (req_ready && idle_m) begin drained = 1; break; end
    end
    if (!drained) checkOutput("drain_bound", 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uncache_bridge.md
Name: uncache_bridge

Overview:
- Downstream consumer of the LSU address-translation result.
- Takes one translated request (paddr plus the uncache flag already resolved) from the memory stage and runs it as a single-beat AXI4-Lite-style transaction on the uncached peripheral bus.
- Returns read data or a write acknowledge to the pipeline.
- Strictly one outstanding access; a timeout protects against dead peripherals (e.g. the 0xbfaf confreg window).

Parameters:
- ADDR_W, 32, physical address width
- DATA_W, 32, data width
- TIMEOUT, 1023, bus-wait cycles before the access is aborted with error

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  pipeline request valid
- req_ready  out  1  bridge can accept a request
- req_we  in  1  1 = store, 0 = load
- req_paddr  in  ADDR_W  translated physical address
- req_wdata  in  DATA_W  store data
- req_wstrb  in  4  store byte strobes
- resp_valid  out  1  response valid
- resp_ready  in  1  pipeline accepts response
- resp_rdata  out  DATA_W  load data (0 for stores)
- resp_err  out  1  bus SLVERR/DECERR or timeout
- ar_valid, ar_ready, ar_addr  out/in/out  1/1/ADDR_W  read address channel
- r_valid, r_ready, r_data, r_resp  in/out/in/in  1/1/DATA_W/2  read data channel
- aw_valid, aw_ready, aw_addr  out/in/out  1/1/ADDR_W  write address channel
- w_valid, w_ready, w_data, w_strb  out/in/out/out  1/1/DATA_W/4  write data channel
- b_valid, b_ready, b_resp  in/out/in  1/1/2  write response channel

Behaviour:
- Reset (rst=0, async): state IDLE; all valid/ready outputs 0 except req_ready=1; resp_rdata=0, resp_err=0, addresses/data 0, timeout counter 0.
- States: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch paddr/wdata/wstrb/we and clear the counter.
  - Go to RD_A if we=0, else WR_AW.
  - req_ready drops the following cycle.
- RD_A:
  - ar_valid=1 with the latched addr, held stable until ar_ready.
  - ar_valid & ar_ready -> RD_D.
- RD_D:
  - r_ready=1.
  - On r_valid: latch r_data; err = (r_resp!=0); go to RESP.
- WR_AW:
  - aw_valid and w_valid both asserted; each channel drops independently on its own handshake (tracked by aw_done/w_done flags).
  - Go to WR_B when both are done, including the same-cycle case.
- WR_B:
  - b_ready=1.
  - On b_valid: err = (b_resp!=0); rdata=0; go to RESP.
- RESP:
  - resp_valid=1 with data and err held stable.
  - resp_valid & resp_ready -> IDLE.
  - resp_ready may be high in the cycle resp_valid first rises (1-cycle handshake).
  - No new request is accepted until back in IDLE.
- Minimum latency with all readies high:
  - Read: req accept cycle 0, AR cycle 1, R cycle 2, resp_valid cycle 3.
  - Write: identical timing.
- Timeout:
  - Counter increments every cycle in RD_A, RD_D, WR_AW or WR_B; it saturates and never wraps.
  - On reaching TIMEOUT: drop all bus valids/readies, set err=1, rdata=0, go to RESP.
  - A late bus response arriving afterwards is ignored; the bridge does not re-handshake it.
- AXI rules: a valid is never deasserted before its ready; addr/data are stable while valid. A ready that arrives in the same cycle that valid first rises is legal.
- resp_err is sticky only within one transaction and cleared on the next accept.
- req_wstrb=0 is still issued as a write (w_strb=0).

Decomposition:
- Shared package/defines header: state encodings (UB_IDLE..UB_RESP, 3 bits), AXI resp codes (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11).
- No sub-module; the timeout counter and channel flags stay inline.

Test Plan:
- Read, zero-wait slave: paddr=0x1faf_f020, bus returns 0xdead_beef OKAY -> ar_addr=0x1faf_f020, resp_valid at cycle 3, rdata=0xdead_beef, err=0.
- Write with w_ready 3 cycles before aw_ready: addr 0x1fd0_0000, wdata=0x1234_5678, strb=4'b0011 -> w drops after its handshake, aw held until ready, one b handshake, resp_valid with err=0, rdata=0.
- Read with r_resp=SLVERR -> resp_err=1; then an OKAY read immediately after -> resp_err=0.
- Dead slave: ar_ready stuck low -> ar_valid held exactly TIMEOUT cycles, then dropped; resp_err=1, rdata=0; a later r_valid is ignored and no second response is produced.
- Backpressure: resp_ready low for 5 cycles -> resp_valid/rdata stable, req_ready=0 throughout; a new req_valid is accepted only after the response handshake.
- Async reset asserted in WR_B -> all bus valids/readies 0 immediately, req_ready=1 after release, and the next read completes normally.
